// File: rtl/cp0_nic.sv
// cp0_nic: nested interrupt controller for the CP0 path.
// Senses interrupt lines (per-channel edge or level), masks them by IE/IM,
// and redirects the PC to a per-channel vector. Nesting is tracked on an
// EPC/mask/channel stack. ERET returns, or tail-chains to a pending channel.
// Ports:
//   clk, clr (async active-high reset)
//   current_pc         : resume PC pushed on entry
//   hardware_interrupt : raw interrupt lines
//   eret               : one-cycle return strobe
//   status_we/wdata    : software write of IE (bit 0) and IM (bits 8+)
//   pc_jump, pc_addr   : PC redirect strobe and target
//   writeback_mask     : 0 blocks writeback for the entry cycle
//   status, epc, depth, active_irq : architectural state
//   overflow, underflow: sticky stack error flags
module cp0_nic #(
  parameter int          NUM_IRQ     = 8,
  parameter int          STACK_DEPTH = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter logic [31:0] INT_BASE    = 32'h0000_1000,
  parameter int          VEC_STRIDE  = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [31:0]                  current_pc,
  input  logic [NUM_IRQ-1:0]           hardware_interrupt,
  input  logic                         eret,
  input  logic                         status_we,
  input  logic [31:0]                  status_wdata,
  output logic                         pc_jump,
  output logic [31:0]                  pc_addr,
  output logic                         writeback_mask,
  output logic [31:0]                  status,
  output logic [31:0]                  epc,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic [4:0]                   active_irq,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_JUMP = 1'b1} state_t;

  // Highest set index; channel NUM_IRQ-1 wins.
  function automatic logic [4:0] top_idx(input logic [NUM_IRQ-1:0] v);
    top_idx = 5'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) top_idx = 5'(i);
    end
  endfunction

  // Keep only mask bits strictly above channel k.
  function automatic logic [NUM_IRQ-1:0] keep_above(input logic [NUM_IRQ-1:0] m,
                                                    input logic [4:0] k);
    for (int i = 0; i < NUM_IRQ; i++) begin
      keep_above[i] = m[i] & (5'(i) > k);
    end
  endfunction

  function automatic logic [31:0] vector(input logic [4:0] k);
    vector = INT_BASE + (32'(k) * 32'(VEC_STRIDE));
  endfunction

  state_t              state_q, state_d;
  logic [NUM_IRQ-1:0]  edge_prev_q, edge_pend_q, edge_pend_d;
  logic                ie_q, ie_d;
  logic [NUM_IRQ-1:0]  im_q, im_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [31:0]         epc_q, epc_d, pc_addr_q, pc_addr_d;
  logic                pc_jump_q, pc_jump_d, wbm_q, wbm_d;
  logic [4:0]          active_q, active_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;

  logic [31:0]         pc_stk [STACK_DEPTH];
  logic [NUM_IRQ-1:0]  im_stk [STACK_DEPTH];
  logic [4:0]          ch_stk [STACK_DEPTH];

  logic [NUM_IRQ-1:0]  pending_s, eligible_s, chain_set_s, im_top_s, take_mask_s;
  logic [AW-1:0]       top_ix_s, below_ix_s;
  logic [31:0]         pc_top_s;
  logic [4:0]          k_enter_s, k_chain_s;
  logic                idle_s, has_depth_s, full_s, ret_take_s;
  logic                do_enter_s, do_chain_s, do_return_s, set_ovf_s, set_unf_s;
  logic [31:0]         unused_wdata_s;

  assign unused_wdata_s = status_wdata;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and event decode.
  always_comb begin
    pending_s   = (EDGE_MASK & edge_pend_q) | (~EDGE_MASK & hardware_interrupt);
    eligible_s  = pending_s & im_q & {NUM_IRQ{ie_q}};
    top_ix_s    = depth_q[AW-1:0] - AW'(1);
    below_ix_s  = depth_q[AW-1:0] - AW'(2);
    im_top_s    = im_stk[top_ix_s];
    pc_top_s    = pc_stk[top_ix_s];
    chain_set_s = pending_s & im_top_s & {NUM_IRQ{ie_q}};
    k_enter_s   = top_idx(eligible_s);
    k_chain_s   = top_idx(chain_set_s);
    idle_s      = (state_q == S_IDLE);
    has_depth_s = (depth_q != '0);
    full_s      = (depth_q == DW'(STACK_DEPTH));
    ret_take_s  = idle_s & eret & has_depth_s;
    do_chain_s  = ret_take_s & (|chain_set_s);
    do_return_s = ret_take_s & ~(|chain_set_s);
    // An eret at depth 0 is ignored, so a request in that cycle still enters.
    do_enter_s  = idle_s & ~ret_take_s & (|eligible_s) & ~full_s;
    set_ovf_s   = idle_s & ~ret_take_s & (|eligible_s) & full_s;
    set_unf_s   = idle_s & eret & ~has_depth_s;
    state_d     = state_q;
    case (state_q)
      S_IDLE:  state_d = (do_enter_s | do_chain_s | do_return_s) ? S_JUMP : S_IDLE;
      S_JUMP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    ie_d        = ie_q;
    im_d        = im_q;
    depth_d     = depth_q;
    epc_d       = epc_q;
    pc_addr_d   = pc_addr_q;
    pc_jump_d   = 1'b0;
    wbm_d       = 1'b1;
    active_d    = active_q;
    ovf_d       = ovf_q | set_ovf_s;
    unf_d       = unf_q | set_unf_s;
    take_mask_s = '0;
    if (do_enter_s) begin
      depth_d     = depth_q + DW'(1);
      im_d        = keep_above(im_q, k_enter_s);
      pc_addr_d   = vector(k_enter_s);
      pc_jump_d   = 1'b1;
      wbm_d       = 1'b0;
      active_d    = k_enter_s;
      take_mask_s = NUM_IRQ'(1) << k_enter_s;
    end else if (do_chain_s) begin
      im_d        = keep_above(im_top_s, k_chain_s);
      epc_d       = pc_top_s;
      pc_addr_d   = vector(k_chain_s);
      pc_jump_d   = 1'b1;
      wbm_d       = 1'b0;
      active_d    = k_chain_s;
      take_mask_s = NUM_IRQ'(1) << k_chain_s;
    end else if (do_return_s) begin
      depth_d     = depth_q - DW'(1);
      epc_d       = pc_top_s;
      im_d        = im_top_s;
      pc_addr_d   = pc_top_s;
      pc_jump_d   = 1'b1;
      active_d    = (depth_q > DW'(1)) ? ch_stk[below_ix_s] : 5'd0;
    end else if (status_we) begin
      // Software write only lands when no hardware update competes for IE/IM.
      ie_d        = status_wdata[0];
      im_d        = status_wdata[8 +: NUM_IRQ];
    end else begin
      ie_d        = ie_q;
    end
    edge_pend_d = (edge_pend_q & ~take_mask_s) |
                  (hardware_interrupt & ~edge_prev_q & EDGE_MASK);
  end

  // Architectural registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      edge_prev_q <= '0;
      edge_pend_q <= '0;
      ie_q        <= 1'b1;
      im_q        <= '1;
      depth_q     <= '0;
      epc_q       <= 32'd0;
      pc_addr_q   <= 32'd0;
      pc_jump_q   <= 1'b0;
      wbm_q       <= 1'b1;
      active_q    <= 5'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      edge_prev_q <= hardware_interrupt;
      edge_pend_q <= edge_pend_d;
      ie_q        <= ie_d;
      im_q        <= im_d;
      depth_q     <= depth_d;
      epc_q       <= epc_d;
      pc_addr_q   <= pc_addr_d;
      pc_jump_q   <= pc_jump_d;
      wbm_q       <= wbm_d;
      active_q    <= active_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Nesting stack; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (do_enter_s) begin
      pc_stk[depth_q[AW-1:0]] <= current_pc;
      im_stk[depth_q[AW-1:0]] <= im_q;
      ch_stk[depth_q[AW-1:0]] <= k_enter_s;
    end else if (do_chain_s) begin
      ch_stk[top_ix_s] <= k_chain_s;
    end
  end

  // Status image: unused bits read as zero.
  always_comb begin
    status                = 32'd0;
    status[0]             = ie_q;
    status[8 +: NUM_IRQ]  = im_q;
  end

  assign pc_jump        = pc_jump_q;
  assign pc_addr        = pc_addr_q;
  assign writeback_mask = wbm_q;
  assign epc            = epc_q;
  assign depth          = depth_q;
  assign active_irq     = active_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;

endmodule

// File: tb/tb_cp0_nic.sv
// tb_cp0_nic: directed self-checking bench for cp0_nic (8 channels,
// 2-deep stack, channel 0 edge sensed, all others level sensed).
module tb_cp0_nic;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] current_pc;
  logic [7:0]  hardware_interrupt;
  logic        eret;
  logic        status_we;
  logic [31:0] status_wdata;
  logic        pc_jump;
  logic [31:0] pc_addr;
  logic        writeback_mask;
  logic [31:0] status;
  logic [31:0] epc;
  logic [1:0]  depth;
  logic [4:0]  active_irq;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;

  cp0_nic #(
    .NUM_IRQ(8), .STACK_DEPTH(2), .EDGE_MASK(8'h01),
    .INT_BASE(32'h0000_1000), .VEC_STRIDE(4)
  ) dut (
    .clk(clk), .clr(clr), .current_pc(current_pc),
    .hardware_interrupt(hardware_interrupt), .eret(eret),
    .status_we(status_we), .status_wdata(status_wdata),
    .pc_jump(pc_jump), .pc_addr(pc_addr), .writeback_mask(writeback_mask),
    .status(status), .epc(epc), .depth(depth), .active_irq(active_irq),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; current_pc = 32'h0000_0200; hardware_interrupt = 8'h00;
    eret = 1'b0; status_we = 1'b0; status_wdata = 32'd0;
    tick(); tick();
    check_eq("rst_pc_jump", {31'd0, pc_jump}, 32'd0);
    check_eq("rst_pc_addr", pc_addr, 32'd0);
    check_eq("rst_wbm", {31'd0, writeback_mask}, 32'd1);
    check_eq("rst_status", status, 32'h0000_FF01);
    check_eq("rst_epc", epc, 32'd0);
    check_eq("rst_depth", {30'd0, depth}, 32'd0);
    check_eq("rst_active", {27'd0, active_irq}, 32'd0);
    check_eq("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    clr = 1'b0;

    // Level entry on channel 3.
    hardware_interrupt = 8'h08;
    tick();
    check_eq("e3_jump", {31'd0, pc_jump}, 32'd1);
    check_eq("e3_addr", pc_addr, 32'h0000_100C);
    check_eq("e3_wbm", {31'd0, writeback_mask}, 32'd0);
    check_eq("e3_depth", {30'd0, depth}, 32'd1);
    check_eq("e3_status", status, 32'h0000_F001);
    check_eq("e3_active", {27'd0, active_irq}, 32'd3);
    current_pc = 32'h0000_0300;
    hardware_interrupt = 8'h28;
    tick();
    check_eq("jump_end_pc_jump", {31'd0, pc_jump}, 32'd0);
    check_eq("jump_end_wbm", {31'd0, writeback_mask}, 32'd1);
    // Preempt by channel 5.
    tick();
    check_eq("e5_jump", {31'd0, pc_jump}, 32'd1);
    check_eq("e5_addr", pc_addr, 32'h0000_1014);
    check_eq("e5_depth", {30'd0, depth}, 32'd2);
    check_eq("e5_status", status, 32'h0000_C001);
    check_eq("e5_active", {27'd0, active_irq}, 32'd5);
    tick();
    hardware_interrupt = 8'h2C;
    tick();
    check_eq("ch2_masked_jump", {31'd0, pc_jump}, 32'd0);
    check_eq("ch2_masked_depth", {30'd0, depth}, 32'd2);
    check_eq("ch2_no_ovf", {31'd0, overflow}, 32'd0);

    // Unwind with lines dropped.
    hardware_interrupt = 8'h00;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("r1_jump", {31'd0, pc_jump}, 32'd1);
    check_eq("r1_addr", pc_addr, 32'h0000_0300);
    check_eq("r1_wbm", {31'd0, writeback_mask}, 32'd1);
    check_eq("r1_status", status, 32'h0000_F001);
    check_eq("r1_depth", {30'd0, depth}, 32'd1);
    check_eq("r1_epc", epc, 32'h0000_0300);
    check_eq("r1_active", {27'd0, active_irq}, 32'd3);
    tick();
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("r2_jump", {31'd0, pc_jump}, 32'd1);
    check_eq("r2_addr", pc_addr, 32'h0000_0200);
    check_eq("r2_status", status, 32'h0000_FF01);
    check_eq("r2_depth", {30'd0, depth}, 32'd0);
    check_eq("r2_active", {27'd0, active_irq}, 32'd0);
    tick();

    // Tail-chain to masked channel 1.
    current_pc = 32'h0000_0400;
    hardware_interrupt = 8'h08;
    tick();
    check_eq("t_e3_addr", pc_addr, 32'h0000_100C);
    hardware_interrupt = 8'h0A;
    tick();
    tick();
    check_eq("t_ch1_masked", {31'd0, pc_jump}, 32'd0);
    hardware_interrupt = 8'h02;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    hardware_interrupt = 8'h00;
    check_eq("tc_jump", {31'd0, pc_jump}, 32'd1);
    check_eq("tc_addr", pc_addr, 32'h0000_1004);
    check_eq("tc_wbm", {31'd0, writeback_mask}, 32'd0);
    check_eq("tc_depth", {30'd0, depth}, 32'd1);
    check_eq("tc_epc", epc, 32'h0000_0400);
    check_eq("tc_status", status, 32'h0000_FC01);
    check_eq("tc_active", {27'd0, active_irq}, 32'd1);
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("tc_ret_addr", pc_addr, 32'h0000_0400);
    check_eq("tc_ret_depth", {30'd0, depth}, 32'd0);
    tick();

    // Edge channel 0 pulsed while IE=0, then enabled.
    status_we = 1'b1; status_wdata = 32'h0000_FF00;
    tick();
    status_we = 1'b0;
    check_eq("ie0_status", status, 32'h0000_FF00);
    current_pc = 32'h0000_0500;
    hardware_interrupt = 8'h01;
    tick();
    hardware_interrupt = 8'h00;
    tick();
    check_eq("edge_ie0_no_jump", {31'd0, pc_jump}, 32'd0);
    status_we = 1'b1; status_wdata = 32'h0000_FF01;
    tick();
    status_we = 1'b0;
    tick();
    check_eq("edge_jump", {31'd0, pc_jump}, 32'd1);
    check_eq("edge_addr", pc_addr, 32'h0000_1000);
    check_eq("edge_status", status, 32'h0000_FE01);
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("edge_ret_addr", pc_addr, 32'h0000_0500);
    check_eq("edge_latch_clear_depth", {30'd0, depth}, 32'd0);
    tick();
    // Held-high edge line: one entry only.
    hardware_interrupt = 8'h01;
    tick();
    check_eq("hold_latch_cycle", {31'd0, pc_jump}, 32'd0);
    tick();
    check_eq("hold_jump", {31'd0, pc_jump}, 32'd1);
    check_eq("hold_addr", pc_addr, 32'h0000_1000);
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("hold_ret_addr", pc_addr, 32'h0000_0500);
    check_eq("hold_ret_depth", {30'd0, depth}, 32'd0);
    tick();
    tick();
    check_eq("hold_no_reentry1", {31'd0, pc_jump}, 32'd0);
    tick();
    check_eq("hold_no_reentry2", {31'd0, pc_jump}, 32'd0);
    hardware_interrupt = 8'h00;
    tick();

    // Overflow with a 2-deep stack.
    current_pc = 32'h0000_0600;
    hardware_interrupt = 8'h02;
    tick();
    check_eq("o1_addr", pc_addr, 32'h0000_1004);
    tick();
    hardware_interrupt = 8'h06;
    tick();
    check_eq("o2_addr", pc_addr, 32'h0000_1008);
    check_eq("o2_status", status, 32'h0000_F801);
    tick();
    hardware_interrupt = 8'h0E;
    tick();
    check_eq("o3_no_jump", {31'd0, pc_jump}, 32'd0);
    check_eq("o3_ovf", {31'd0, overflow}, 32'd1);
    check_eq("o3_depth", {30'd0, depth}, 32'd2);
    hardware_interrupt = 8'h00;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("o_unwind_depth", {30'd0, depth}, 32'd0);
    check_eq("o_ovf_sticky", {31'd0, overflow}, 32'd1);
    tick();

    // ERET at depth 0.
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("u_no_jump", {31'd0, pc_jump}, 32'd0);
    check_eq("u_flag", {31'd0, underflow}, 32'd1);
    check_eq("u_depth", {30'd0, depth}, 32'd0);
    // ERET at depth 0 with a request, plus a colliding status write.
    eret = 1'b1; hardware_interrupt = 8'h08;
    status_we = 1'b1; status_wdata = 32'd0;
    tick();
    eret = 1'b0; status_we = 1'b0;
    check_eq("u_enter_jump", {31'd0, pc_jump}, 32'd1);
    check_eq("u_enter_addr", pc_addr, 32'h0000_100C);
    check_eq("collide_status", status, 32'h0000_F001);

    // Reset while in JUMP.
    clr = 1'b1;
    #1;
    check_eq("clr_jump", {31'd0, pc_jump}, 32'd0);
    check_eq("clr_addr", pc_addr, 32'd0);
    check_eq("clr_wbm", {31'd0, writeback_mask}, 32'd1);
    check_eq("clr_depth", {30'd0, depth}, 32'd0);
    check_eq("clr_status", status, 32'h0000_FF01);
    check_eq("clr_flags", {30'd0, overflow, underflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
